// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for sram_controller: FSM state encoding, address-map widths and half-word selects.
package sram_ctrl_pkg;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 18;
  localparam int WORD_AW = SRAM_AW - 1;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_LO, ST_RD_HI, ST_WR_LO, ST_WR_HI, ST_WAIT, ST_DONE
  } state_t;

  // Word index into the SRAM; anything outside the 2^17-word window wraps.
  function automatic logic [WORD_AW-1:0] word_index(input logic [31:0] addr,
                                                    input logic [31:0] base);
    return WORD_AW'((addr - base) >> 2);
  endfunction
endpackage

// File: rtl/sram_ctrl_wait_counter.sv
// Busy-cycle counter for the SRAM_CTRL_FIXED_LATENCY_EN build of sram_controller.
// tc is high while the count equals TERMINAL; clr has priority over en.
module sram_ctrl_wait_counter #(
  parameter int unsigned TERMINAL = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 3'd1;
    end
  end

  assign tc = (count == 3'(TERMINAL));
endmodule

// File: rtl/sram_controller.sv
// 32-bit load/store to 16-bit SRAM bridge: two half-word cycles per access, ready low while busy.
// Optional SRAM_CTRL_FIXED_LATENCY_EN pads every access to exactly ACCESS_CYCLES busy cycles.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
  parameter int unsigned ACCESS_CYCLES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                ready,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N
);
  if (ACCESS_CYCLES < 3 || ACCESS_CYCLES > 8) begin : g_bad_access_cycles
    $error("sram_controller: ACCESS_CYCLES must lie in 3..8");
  end

  state_t             state;
  state_t             hi_next;
  logic [WORD_AW-1:0] word_q;
  logic [31:0]        wdata_q;
  logic               req;
  logic               writing;
  logic               hi_half;

  assign req = rd_en | wr_en;

`ifdef SRAM_CTRL_FIXED_LATENCY_EN
  logic busy;
  logic wait_tc;

  // Counts the request cycle plus every cycle spent in LO/HI/WAIT.
  assign busy = (state == ST_IDLE && req) || state == ST_RD_LO || state == ST_RD_HI ||
                state == ST_WR_LO || state == ST_WR_HI || state == ST_WAIT;

  sram_ctrl_wait_counter #(
    .TERMINAL(ACCESS_CYCLES - 1)
  ) u_wait_counter (
    .clk(clk),
    .rst(rst),
    .clr(!busy),
    .en (busy),
    .tc (wait_tc)
  );

  assign hi_next = wait_tc ? ST_DONE : ST_WAIT;
`else
  assign hi_next = ST_DONE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            word_q  <= word_index(address, BASE_ADDR);
            wdata_q <= write_data;
            state   <= wr_en ? ST_WR_LO : ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          read_data[15:0] <= SRAM_DQ;
          state           <= ST_RD_HI;
        end
        ST_RD_HI: begin
          read_data[31:16] <= SRAM_DQ;
          state            <= hi_next;
        end
        ST_WR_LO: state <= ST_WR_HI;
        ST_WR_HI: state <= hi_next;
`ifdef SRAM_CTRL_FIXED_LATENCY_EN
        ST_WAIT:  state <= hi_next;
`endif
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Reset overrides the strobe and bus so an abandoned write cannot land on the reset edge.
  assign writing   = (state == ST_WR_LO || state == ST_WR_HI) && !rst;
  assign hi_half   = (state == ST_RD_HI || state == ST_WR_HI);
  assign SRAM_WE_N = ~writing;
  assign SRAM_ADDR = rst ? '0 : {word_q, hi_half ? HALF_HI : HALF_LO};
  assign SRAM_DQ   = writing ? (hi_half ? wdata_q[31:16] : wdata_q[15:0]) : 'z;

  assign ready = (state == ST_IDLE) ? ~req : (state == ST_DONE);

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller with an attached SRAM device and a cycle-level behavioural model.
module tb_sram_controller;
`ifdef SRAM_CTRL_FIXED_LATENCY_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  localparam int MEM_WORDS = 262144;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_controller #(
    .BASE_ADDR    (32'd1024),
    .ACCESS_CYCLES(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N)
  );

  // Asynchronous-read SRAM device; writes land on the clock edge while WE_N is low.
  logic [15:0] sram [0:MEM_WORDS-1] = '{default: 16'h0};
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR] : 16'bz;
  always @(posedge clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) sram[SRAM_ADDR] = SRAM_DQ;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lo_half(input logic [31:0] a);
    return int'((((a - 32'd1024) >> 2) & 32'h1FFFF) * 2);
  endfunction

  // Behavioural model: cycles since acceptance, expected memory contents and load result.
  logic [15:0] exp_mem [0:MEM_WORDS-1] = '{default: 16'h0};
  int          since = 0;
  logic        cur_wr = 1'b0;
  logic [31:0] cur_data = 32'd0;
  int          cur_lo = 0;
  logic [31:0] exp_rd = 32'd0;
  bit          run = 1'b1;
  int          touched[$];

  always @(negedge clk) begin
    if (run) begin
      if (rst) begin
        chk("we_n_in_reset", 32'(SRAM_WE_N), 32'd1);
        chk("addr_in_reset", 32'(SRAM_ADDR), 32'd0);
        since  = 0;
        exp_rd = 32'd0;
      end else if (since == 0) begin
        chk("ready_idle", 32'(ready), 32'(!(rd_en | wr_en)));
        chk("read_data_hold", read_data, exp_rd);
        chk("we_n_idle", 32'(SRAM_WE_N), 32'd1);
        if (rd_en | wr_en) begin
          cur_wr   = wr_en;
          cur_data = write_data;
          cur_lo   = lo_half(address);
          since    = 1;
        end
      end else if (since < LAT) begin
        chk("ready_busy", 32'(ready), 32'd0);
        if (since <= 2) begin
          int h;
          h = (since == 2) ? 1 : 0;
          chk("sram_addr", 32'(SRAM_ADDR), 32'(cur_lo + h));
          chk("we_n_access", 32'(SRAM_WE_N), 32'(!cur_wr));
          if (cur_wr) begin
            logic [15:0] half;
            half = (h == 1) ? cur_data[31:16] : cur_data[15:0];
            chk("dq_write", 32'(SRAM_DQ), 32'(half));
            exp_mem[cur_lo + h] = half;
            touched.push_back(cur_lo + h);
          end
        end else begin
          chk("we_n_wait", 32'(SRAM_WE_N), 32'd1);
        end
        since++;
      end else begin
        chk("ready_done", 32'(ready), 32'd1);
        if (!cur_wr) exp_rd = {exp_mem[cur_lo + 1], exp_mem[cur_lo]};
        chk("read_data_done", read_data, exp_rd);
        chk("mem_lo", 32'(sram[cur_lo]), 32'(exp_mem[cur_lo]));
        chk("mem_hi", 32'(sram[cur_lo + 1]), 32'(exp_mem[cur_lo + 1]));
        since = 0;
      end
    end
  end

  // Presents one request (called just after a rising edge) and holds it until ready.
  task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, output int low);
    wr_en = w; rd_en = r; address = a; write_data = d;
    low = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      low++;
      if (low > 40) begin
        checks++;
        failures++;
        $display("FAIL access_timeout actual=%0d busy cycles required=%0d", low, LAT);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle(input int n);
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int low;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_sram_addr", 32'(SRAM_ADDR), 32'd0);
    chk("reset_we_n", 32'(SRAM_WE_N), 32'd1);
    @(posedge clk); #1;

    // Reset during the high half of a store leaves only the low half written.
    wr_en = 1'b1; address = 32'd1024; write_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_sram1", 32'(sram[1]), 32'h0);
    chk("abort_sram0", 32'(sram[0]), 32'hFFFF);
    @(posedge clk); #1;

    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, low);
    chk("t1_wr_latency", low, LAT);
    chk("t1_sram0", 32'(sram[0]), 32'hBEEF);
    chk("t1_sram1", 32'(sram[1]), 32'hDEAD);
    go_idle(1);
    do_access(1'b0, 1'b1, 32'd1024, 32'd0, low);
    chk("t1_rd_latency", low, LAT);
    chk("t1_read_data", read_data, 32'hDEADBEEF);
    go_idle(2);

    do_access(1'b1, 1'b0, 32'd1032, 32'h12345678, low);
    chk("t2_sram4", 32'(sram[4]), 32'h5678);
    chk("t2_sram5", 32'(sram[5]), 32'h1234);
    chk("t2_sram0", 32'(sram[0]), 32'hBEEF);
    chk("t2_sram3", 32'(sram[3]), 32'h0);
    go_idle(1);

    do_access(1'b1, 1'b1, 32'd1028, 32'hA5A5_0F0F, low);
    chk("t3_latency", low, LAT);
    chk("t3_sram2", 32'(sram[2]), 32'h0F0F);
    chk("t3_sram3", 32'(sram[3]), 32'hA5A5);
    chk("t3_read_data", read_data, 32'hDEADBEEF);
    go_idle(1);

    // Back-to-back loads with the request held across DONE.
    do_access(1'b0, 1'b1, 32'd1024, 32'd0, low);
    chk("t5_first", read_data, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'd1032, 32'd0, low);
    chk("t5_second_latency", low, LAT);
    chk("t5_second", read_data, 32'h12345678);
    go_idle(1);

    for (int i = 0; i < 60; i++) begin
      int k, mode, kind;
      logic [31:0] a;
      k    = $urandom_range(0, 15);
      mode = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      if (mode == 2)      a = 32'd1024 - 32'(4 * (k + 1));
      else if (mode == 3) a = 32'd1024 + 32'(4 * (k + 131072));
      else                a = 32'd1024 + 32'(4 * k);
      do_access(kind >= 2, kind != 2, a, $urandom, low);
      chk("rand_latency", low, LAT);
      if ($urandom_range(0, 2) != 0) go_idle($urandom_range(1, 3));
    end

    go_idle(3);
    run = 1'b0;
    foreach (touched[i]) chk("mem_final", 32'(sram[touched[i]]), 32'(exp_mem[touched[i]]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
